// File: rtl/binarize_pkg.sv
// Shared types and constants for the HSV binarizer threshold controller.
package binarize_pkg;

    localparam int unsigned H_W = 9;
    localparam int unsigned S_W = 7;
    localparam int unsigned V_W = 6;

    localparam logic [2:0] FIELD_H_MAX  = 3'd0;
    localparam logic [2:0] FIELD_H_MIN  = 3'd1;
    localparam logic [2:0] FIELD_S_MAX  = 3'd2;
    localparam logic [2:0] FIELD_S_MIN  = 3'd3;
    localparam logic [2:0] FIELD_V_MAX  = 3'd4;
    localparam logic [2:0] FIELD_V_MIN  = 3'd5;
    localparam logic [2:0] FIELD_SEL    = 3'd6;
    localparam logic [2:0] FIELD_COMMIT = 3'd7;

    localparam logic [H_W-1:0] H_MAX_DEF = 9'd359;
    localparam logic [H_W-1:0] H_MIN_DEF = 9'd0;
    localparam logic [S_W-1:0] S_MAX_DEF = 7'd100;
    localparam logic [S_W-1:0] S_MIN_DEF = 7'd0;
    localparam logic [V_W-1:0] V_MAX_DEF = 6'd45;
    localparam logic [V_W-1:0] V_MIN_DEF = 6'd0;

    typedef struct packed {
        logic [H_W-1:0] h_max;
        logic [H_W-1:0] h_min;
        logic [S_W-1:0] s_max;
        logic [S_W-1:0] s_min;
        logic [V_W-1:0] v_max;
        logic [V_W-1:0] v_min;
    } thresh_set_t;

    localparam thresh_set_t PASS_ALL = '{
        h_max: H_MAX_DEF, h_min: H_MIN_DEF,
        s_max: S_MAX_DEF, s_min: S_MIN_DEF,
        v_max: V_MAX_DEF, v_min: V_MIN_DEF
    };

    typedef enum logic [1:0] {StIdle, StFrame, StDrain, StReport} state_t;

endpackage

// File: rtl/thresh_bank.sv
// Shadow/active threshold storage, frame-safe apply and selected-class output register.
// THRESH_READBACK_EN adds a registered shadow readback port.
module thresh_bank
    import binarize_pkg::*;
#(
    parameter int unsigned NUM_CLASS = 4,
    parameter int unsigned CLS_W     = $clog2(NUM_CLASS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CLS_W+2:0] wr_addr,
    input  logic [8:0]       wr_data,
    input  logic             idle,
`ifdef THRESH_READBACK_EN
    input  logic [CLS_W+2:0] rd_addr,
    output logic [8:0]       rd_data,
`endif
    output logic             pending,
    output thresh_set_t      thresh
);

    thresh_set_t      shadow_q [NUM_CLASS];
    thresh_set_t      shadow_d [NUM_CLASS];
    thresh_set_t      active_q [NUM_CLASS];
    logic [CLS_W-1:0] shadow_sel_q, shadow_sel_d;
    logic [CLS_W-1:0] active_sel_q;
    logic             pending_q, pending_d;
    thresh_set_t      thresh_q;
    logic             apply;

    logic [CLS_W-1:0] wr_cls;
    logic [2:0]       wr_fld;

    assign wr_cls = wr_addr[CLS_W+2:3];
    assign wr_fld = wr_addr[2:0];
    // A pending commit lands as soon as no frame is in flight.
    assign apply  = pending_q && idle;

    always_comb begin
        shadow_d     = shadow_q;
        shadow_sel_d = shadow_sel_q;
        pending_d    = pending_q;
        if (apply) pending_d = 1'b0;
        if (wr_en) begin
            case (wr_fld)
                FIELD_H_MAX:  shadow_d[wr_cls].h_max = wr_data[H_W-1:0];
                FIELD_H_MIN:  shadow_d[wr_cls].h_min = wr_data[H_W-1:0];
                FIELD_S_MAX:  shadow_d[wr_cls].s_max = wr_data[S_W-1:0];
                FIELD_S_MIN:  shadow_d[wr_cls].s_min = wr_data[S_W-1:0];
                FIELD_V_MAX:  shadow_d[wr_cls].v_max = wr_data[V_W-1:0];
                FIELD_V_MIN:  shadow_d[wr_cls].v_min = wr_data[V_W-1:0];
                FIELD_SEL:    shadow_sel_d = wr_data[CLS_W-1:0];
                FIELD_COMMIT: pending_d = 1'b1;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                shadow_q[i] <= PASS_ALL;
                active_q[i] <= PASS_ALL;
            end
            shadow_sel_q <= '0;
            active_sel_q <= '0;
            pending_q    <= 1'b0;
            thresh_q     <= PASS_ALL;
        end else begin
            shadow_q     <= shadow_d;
            shadow_sel_q <= shadow_sel_d;
            pending_q    <= pending_d;
            // Copies pre-write shadow contents, so a same-cycle write waits for the next commit.
            if (apply) begin
                active_q     <= shadow_q;
                active_sel_q <= shadow_sel_q;
            end
            thresh_q <= active_q[active_sel_q];
        end
    end

    assign pending = pending_q;
    assign thresh  = thresh_q;

`ifdef THRESH_READBACK_EN
    logic [CLS_W-1:0] rd_cls;
    logic [2:0]       rd_fld;
    logic [8:0]       rd_mux;
    logic [8:0]       rd_data_q;

    assign rd_cls = rd_addr[CLS_W+2:3];
    assign rd_fld = rd_addr[2:0];

    always_comb begin
        rd_mux = '0;
        case (rd_fld)
            FIELD_H_MAX:  rd_mux = 9'(shadow_q[rd_cls].h_max);
            FIELD_H_MIN:  rd_mux = 9'(shadow_q[rd_cls].h_min);
            FIELD_S_MAX:  rd_mux = 9'(shadow_q[rd_cls].s_max);
            FIELD_S_MIN:  rd_mux = 9'(shadow_q[rd_cls].s_min);
            FIELD_V_MAX:  rd_mux = 9'(shadow_q[rd_cls].v_max);
            FIELD_V_MIN:  rd_mux = 9'(shadow_q[rd_cls].v_min);
            FIELD_SEL:    rd_mux = 9'(shadow_sel_q);
            FIELD_COMMIT: rd_mux = {8'b0, pending_q};
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_mux;
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/binarize_thresh_ctrl.sv
// HSV binarizer controller: frame FSM, saturating pixel/hit counters, threshold bank.
// THRESH_READBACK_EN adds RD_ADDR/RD_DATA for shadow register readback.
module binarize_thresh_ctrl
    import binarize_pkg::*;
#(
    parameter int unsigned NUM_CLASS = 4,
    parameter int unsigned CNT_W     = 19,
    parameter int unsigned CLS_W     = $clog2(NUM_CLASS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_EN,
    input  logic [CLS_W+2:0] WR_ADDR,
    input  logic [8:0]       WR_DATA,
    input  logic             FRAME_START,
    input  logic             FRAME_END,
    input  logic             BIN_VALID,
    input  logic             BIN_OUT,
`ifdef THRESH_READBACK_EN
    input  logic [CLS_W+2:0] RD_ADDR,
    output logic [8:0]       RD_DATA,
`endif
    output logic [H_W-1:0]   H_MAX,
    output logic [H_W-1:0]   H_MIN,
    output logic [S_W-1:0]   S_MAX,
    output logic [S_W-1:0]   S_MIN,
    output logic [V_W-1:0]   V_MAX,
    output logic [V_W-1:0]   V_MIN,
    output logic [CNT_W-1:0] FRAME_PIXELS,
    output logic [CNT_W-1:0] FRAME_HITS,
    output logic             REPORT_VALID,
    output logic             PENDING,
    output logic             BUSY
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pix_cnt_q, hit_cnt_q;
    logic [CNT_W-1:0] frame_pixels_q, frame_hits_q;
    logic             report_valid_q;
    logic             counting;
    logic             clear;
    thresh_set_t      thresh;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (FRAME_START) state_d = StFrame;
            StFrame:  if (FRAME_END) state_d = StDrain;
            StDrain:  state_d = StReport;
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // DRAIN keeps counting to catch the binarizer's last delayed VALID.
    assign counting = (state_q == StFrame) || (state_q == StDrain);
    assign clear    = (state_q == StIdle) && FRAME_START;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pix_cnt_q <= '0;
            hit_cnt_q <= '0;
        end else if (clear) begin
            pix_cnt_q <= '0;
            hit_cnt_q <= '0;
        end else if (counting && BIN_VALID) begin
            if (!(&pix_cnt_q)) pix_cnt_q <= pix_cnt_q + 1'b1;
            if (BIN_OUT && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_pixels_q <= '0;
            frame_hits_q   <= '0;
            report_valid_q <= 1'b0;
        end else begin
            report_valid_q <= (state_q == StReport);
            if (state_q == StReport) begin
                frame_pixels_q <= pix_cnt_q;
                frame_hits_q   <= hit_cnt_q;
            end
        end
    end

    thresh_bank #(
        .NUM_CLASS (NUM_CLASS),
        .CLS_W     (CLS_W)
    ) u_thresh_bank (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (WR_EN),
        .wr_addr (WR_ADDR),
        .wr_data (WR_DATA),
        .idle    (state_q == StIdle),
`ifdef THRESH_READBACK_EN
        .rd_addr (RD_ADDR),
        .rd_data (RD_DATA),
`endif
        .pending (PENDING),
        .thresh  (thresh)
    );

    assign H_MAX        = thresh.h_max;
    assign H_MIN        = thresh.h_min;
    assign S_MAX        = thresh.s_max;
    assign S_MIN        = thresh.s_min;
    assign V_MAX        = thresh.v_max;
    assign V_MIN        = thresh.v_min;
    assign FRAME_PIXELS = frame_pixels_q;
    assign FRAME_HITS   = frame_hits_q;
    assign REPORT_VALID = report_valid_q;
    assign BUSY         = counting;

endmodule

// File: tb/tb_binarize_thresh_ctrl.sv
// Directed self-checking bench for binarize_thresh_ctrl (narrow counters to reach saturation quickly).
module tb_binarize_thresh_ctrl;

    localparam int unsigned NUM_CLASS = 4;
    localparam int unsigned CLS_W     = 2;
    localparam int unsigned CNT_W     = 8;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             WR_EN = 1'b0;
    logic [CLS_W+2:0] WR_ADDR = '0;
    logic [8:0]       WR_DATA = '0;
    logic             FRAME_START = 1'b0;
    logic             FRAME_END = 1'b0;
    logic             BIN_VALID = 1'b0;
    logic             BIN_OUT = 1'b0;
    logic [8:0]       H_MAX, H_MIN;
    logic [6:0]       S_MAX, S_MIN;
    logic [5:0]       V_MAX, V_MIN;
    logic [CNT_W-1:0] FRAME_PIXELS, FRAME_HITS;
    logic             REPORT_VALID, PENDING, BUSY;
`ifdef THRESH_READBACK_EN
    logic [CLS_W+2:0] RD_ADDR = '0;
    logic [8:0]       RD_DATA;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int rv_seen;

    binarize_thresh_ctrl #(
        .NUM_CLASS (NUM_CLASS),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .WR_EN        (WR_EN),
        .WR_ADDR      (WR_ADDR),
        .WR_DATA      (WR_DATA),
        .FRAME_START  (FRAME_START),
        .FRAME_END    (FRAME_END),
        .BIN_VALID    (BIN_VALID),
        .BIN_OUT      (BIN_OUT),
`ifdef THRESH_READBACK_EN
        .RD_ADDR      (RD_ADDR),
        .RD_DATA      (RD_DATA),
`endif
        .H_MAX        (H_MAX),
        .H_MIN        (H_MIN),
        .S_MAX        (S_MAX),
        .S_MIN        (S_MIN),
        .V_MAX        (V_MAX),
        .V_MIN        (V_MIN),
        .FRAME_PIXELS (FRAME_PIXELS),
        .FRAME_HITS   (FRAME_HITS),
        .REPORT_VALID (REPORT_VALID),
        .PENDING      (PENDING),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] cls, input logic [2:0] fld, input logic [8:0] data);
        WR_EN   = 1'b1;
        WR_ADDR = {cls, fld};
        WR_DATA = data;
        tick();
        WR_EN   = 1'b0;
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        RST = 1'b0;
        check("rst_h_max", 32'(H_MAX), 359);
        check("rst_h_min", 32'(H_MIN), 0);
        check("rst_s_max", 32'(S_MAX), 100);
        check("rst_v_max", 32'(V_MAX), 45);
        check("rst_pixels", 32'(FRAME_PIXELS), 0);
        check("rst_rv", 32'(REPORT_VALID), 0);
        check("rst_pending", 32'(PENDING), 0);
        check("rst_busy", 32'(BUSY), 0);

        // 1: 10 pixels, 4 hits, report three cycles after FRAME_END
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
        check("t1_busy", 32'(BUSY), 1);
        for (int i = 0; i < 10; i++) begin
            BIN_VALID = 1'b1;
            BIN_OUT   = (i < 4);
            tick();
        end
        BIN_VALID = 1'b0;
        BIN_OUT   = 1'b0;
        FRAME_END = 1'b1;
        tick();
        FRAME_END = 1'b0;
        check("t1_rv_drain", 32'(REPORT_VALID), 0);
        tick();
        check("t1_rv_report", 32'(REPORT_VALID), 0);
        tick();
        check("t1_rv", 32'(REPORT_VALID), 1);
        check("t1_pixels", 32'(FRAME_PIXELS), 10);
        check("t1_hits", 32'(FRAME_HITS), 4);
        check("t1_busy_idle", 32'(BUSY), 0);
        tick();
        check("t1_rv_pulse", 32'(REPORT_VALID), 0);

        // 2: commit mid-frame waits for the frame to finish; FRAME_START in FRAME ignored
        wr(2'd1, 3'd0, 9'd40);
        wr(2'd1, 3'd1, 9'd20);
        wr(2'd3, 3'd6, 9'd1);
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
        wr(2'd0, 3'd7, 9'd0);
        check("t2_pending", 32'(PENDING), 1);
        check("t2_h_hold", 32'(H_MAX), 359);
        BIN_VALID = 1'b1;
        BIN_OUT   = 1'b1;
        tick();
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
        BIN_OUT     = 1'b0;
        tick();
        BIN_VALID = 1'b0;
        check("t2_busy_restart", 32'(BUSY), 1);
        FRAME_END = 1'b1;
        tick();
        FRAME_END = 1'b0;
        check("t2_h_drain", 32'(H_MAX), 359);
        tick();
        tick();
        check("t2_rv", 32'(REPORT_VALID), 1);
        check("t2_pixels", 32'(FRAME_PIXELS), 3);
        check("t2_hits", 32'(FRAME_HITS), 2);
        check("t2_pending_rep", 32'(PENDING), 1);
        tick();
        check("t2_pending_clr", 32'(PENDING), 0);
        check("t2_h_apply_cyc", 32'(H_MAX), 359);
        tick();
        check("t2_h_max", 32'(H_MAX), 40);
        check("t2_h_min", 32'(H_MIN), 20);

        // 3: commit in IDLE, truncation, write during the apply cycle
        wr(2'd1, 3'd2, 9'h1C8);
        wr(2'd1, 3'd4, 9'd30);
        check("t3_s_shadow", 32'(S_MAX), 100);
        wr(2'd0, 3'd7, 9'd0);
        check("t3_pending", 32'(PENDING), 1);
        wr(2'd1, 3'd5, 9'd7);
        check("t3_pending_clr", 32'(PENDING), 0);
        tick();
        check("t3_s_max", 32'(S_MAX), 72);
        check("t3_v_max", 32'(V_MAX), 30);
        check("t3_v_min_pre", 32'(V_MIN), 0);
        wr(2'd0, 3'd7, 9'd0);
        tick();
        tick();
        check("t3_v_min", 32'(V_MIN), 7);

        // 4: valid in IDLE ignored, valid in DRAIN counted, FRAME_START in REPORT dropped
        BIN_VALID = 1'b1;
        BIN_OUT   = 1'b1;
        tick();
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
        BIN_OUT     = 1'b0;
        tick();
        BIN_OUT   = 1'b1;
        FRAME_END = 1'b1;
        tick();
        FRAME_END = 1'b0;
        tick();
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
        BIN_VALID   = 1'b0;
        BIN_OUT     = 1'b0;
        check("t4_rv", 32'(REPORT_VALID), 1);
        check("t4_pixels", 32'(FRAME_PIXELS), 3);
        check("t4_hits", 32'(FRAME_HITS), 2);
        check("t4_busy", 32'(BUSY), 0);
        FRAME_END = 1'b1;
        tick();
        FRAME_END = 1'b0;
        check("t4_end_idle", 32'(BUSY), 0);

        // 5: saturation, then reset mid-frame
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
        BIN_VALID   = 1'b1;
        BIN_OUT     = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
        BIN_VALID = 1'b0;
        BIN_OUT   = 1'b0;
        FRAME_END = 1'b1;
        tick();
        FRAME_END = 1'b0;
        tick();
        tick();
        check("t5_rv", 32'(REPORT_VALID), 1);
        check("t5_pix_sat", 32'(FRAME_PIXELS), 255);
        check("t5_hit_sat", 32'(FRAME_HITS), 255);
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
        wr(2'd0, 3'd7, 9'd0);
        BIN_VALID = 1'b1;
        tick();
        tick();
        BIN_VALID = 1'b0;
        check("t5_pend_pre", 32'(PENDING), 1);
        RST = 1'b1;
        #1;
        check("t5_rst_h_max", 32'(H_MAX), 359);
        check("t5_rst_v_min", 32'(V_MIN), 0);
        check("t5_rst_pixels", 32'(FRAME_PIXELS), 0);
        check("t5_rst_pending", 32'(PENDING), 0);
        check("t5_rst_busy", 32'(BUSY), 0);
        tick();
        RST     = 1'b0;
        rv_seen = 0;
        FRAME_END = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            FRAME_END = 1'b0;
            if (REPORT_VALID) rv_seen++;
        end
        check("t5_no_report", 32'(rv_seen), 0);
        check("t5_busy_after", 32'(BUSY), 0);

`ifdef THRESH_READBACK_EN
        // 6: shadow readback
        wr(2'd2, 3'd3, 9'd17);
        RD_ADDR = {2'd2, 3'd3};
        tick();
        check("t6_rd_s_min", 32'(RD_DATA), 17);
        wr(2'd0, 3'd6, 9'd3);
        RD_ADDR = {2'd0, 3'd6};
        tick();
        check("t6_rd_sel", 32'(RD_DATA), 3);
        RD_ADDR = {2'd1, 3'd0};
        tick();
        check("t6_rd_h_max", 32'(RD_DATA), 359);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
